// File: rtl/mux_arb_n.sv
// N-channel registered multiplexer/arbiter. Selects one valid channel per cycle,
// either by external select or round-robin, into a one-entry output buffer.
module mux_arb_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      S,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int             CW  = SELW + 1;
    localparam logic [CW-1:0]  N_C = CW'(N);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [CW-1:0]    cand;

    assign load_en = !out_valid_q || out_ready;

    // Grant selection never looks at in_data, keeping in_ready free of data paths.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (mode) begin
            // Walk from farthest to nearest so the first valid after ptr wins.
            for (int k = N; k >= 1; k--) begin
                cand = {1'b0, ptr_q} + CW'(k);
                if (cand >= N_C) begin
                    cand = cand - N_C;
                end
                if (in_valid[cand[SELW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[SELW-1:0];
                end
            end
        end else begin
            if (({1'b0, S} < N_C) && in_valid[S]) begin
                gnt_any = 1'b1;
                gnt_idx = S;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && gnt_any) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_data_d = in_data[gnt_idx*WIDTH +: WIDTH];
                out_sel_d  = gnt_idx;
                ptr_d      = gnt_idx;
            end
        end
    end

    // ptr resets to N-1 so the first round-robin scan begins at channel 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed self-checking bench for mux_arb_n (N=4, WIDTH=8).
module tb_mux_arb_n;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic                 mode;
    logic [SELW-1:0]      S;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_valid;
    logic                 out_ready;

    int n_cmp = 0;
    int n_mis = 0;

    logic [WIDTH-1:0] lut [4];
    logic [3:0]       oh;

    mux_arb_n #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .S         (S),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [SELW-1:0] sel,
                           input logic [WIDTH-1:0] d);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out_sel"},   32'(out_sel),   32'(sel));
        chk({tag, ".out_data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        lut[0] = 8'hAA; lut[1] = 8'hBB; lut[2] = 8'hCC; lut[3] = 8'hDD;
        rst_n     = 1'b0;
        in_data   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        in_valid  = 4'b1111;
        mode      = 1'b1;
        S         = '0;
        out_ready = 1'b1;

        // Reset held for two cycles with all channels valid
        tick();
        chk("rst1.in_ready", 32'(in_ready), 32'h0);
        chk_out("rst1", 1'b0, 2'd0, 8'h00);
        tick();
        chk("rst2.in_ready", 32'(in_ready), 32'h0);
        chk_out("rst2", 1'b0, 2'd0, 8'h00);

        // Release: round-robin starts at channel 0
        rst_n = 1'b1;
        #1;
        chk("rr_first.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("rr_first", 1'b1, 2'd0, 8'hAA);

        // Round-robin, all valid: 1,2,3,0,1
        for (int i = 1; i <= 5; i++) begin
            oh = 4'b0001 << (i % 4);
            chk($sformatf("rr_all%0d.in_ready", i), 32'(in_ready), 32'(oh));
            tick();
            chk_out($sformatf("rr_all%0d", i), 1'b1, SELW'(i % 4), lut[i % 4]);
        end

        // Round-robin with channels 0 and 2 valid, ptr at 1: 2,0,2,0
        in_valid = 4'b0101;
        #1;
        for (int i = 0; i < 4; i++) begin
            oh = (i % 2 == 0) ? 4'b0100 : 4'b0001;
            chk($sformatf("rr_sparse%0d.in_ready", i), 32'(in_ready), 32'(oh));
            tick();
            chk_out($sformatf("rr_sparse%0d", i), 1'b1, (i % 2 == 0) ? 2'd2 : 2'd0,
                    (i % 2 == 0) ? 8'hCC : 8'hAA);
        end

        // Fixed mode, S cycles 0..3
        mode     = 1'b0;
        in_valid = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            S = SELW'(s);
            #1;
            oh = 4'b0001 << s;
            chk($sformatf("fix%0d.in_ready", s), 32'(in_ready), 32'(oh));
            tick();
            chk_out($sformatf("fix%0d", s), 1'b1, SELW'(s), lut[s]);
        end

        // Fixed mode, selected channel idle: held word drains, no reload
        S        = 2'd2;
        in_valid = 4'b1011;
        #1;
        chk("fix_idle.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("fix_idle", 1'b0, 2'd3, 8'hDD);

        // Backpressure: load 5A from channel 1, then stall three cycles
        in_data  = {8'hDD, 8'hCC, 8'h5A, 8'hAA};
        in_valid = 4'b1111;
        S        = 2'd1;
        tick();
        chk_out("bp_load", 1'b1, 2'd1, 8'h5A);
        mode      = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall%0d.in_ready", i), 32'(in_ready), 32'h0);
            tick();
            chk_out($sformatf("bp_stall%0d", i), 1'b1, 2'd1, 8'h5A);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("bp_release", 1'b1, 2'd2, 8'hCC);

        // Mode switch while a word is held under backpressure
        out_ready = 1'b0;
        mode      = 1'b0;
        S         = 2'd3;
        #1;
        chk("msw_hold.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("msw_hold", 1'b1, 2'd2, 8'hCC);
        out_ready = 1'b1;
        #1;
        chk("msw_next.in_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("msw_next", 1'b1, 2'd3, 8'hDD);

        // Move ptr to 1, then reset mid-stream
        S = 2'd1;
        tick();
        chk_out("pre_rst", 1'b1, 2'd1, 8'h5A);
        mode  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("mid_rst", 1'b0, 2'd0, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("post_rst", 1'b1, 2'd0, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
